wb_mem_arbiter: RTL
===================

// Module: wb_mem_arbiter
// PURPOSE
//  Two-master Wishbone arbiter sharing the single-port program memory between instruction
//  fetch (m0) and load/store data (m1). Sits between the CPU bus masters and the memory
//  slave. Grants one master at a time, routes its cycle to the slave and returns ack/err/rdata.
//  Adds a bus watchdog that errors a stalled transfer.
// PARAMETERS
//  TimeoutCycles  default 16  cycles in BUSY without slave ack/err before the arbiter errors (>=2)
//  CntWidth       default 5   watchdog counter width; must satisfy 2**CntWidth > TimeoutCycles
// PORTS
//  clk_in       in   1   single clock; all state on posedge
//  reset_in     in   1   reset, asynchronous, active-high
//  m0_bus       wb_bus.slave   -   instruction-fetch master port (higher fixed priority)
//  m1_bus       wb_bus.slave   -   data master port
//  s_bus        wb_bus.master  -   to program memory slave
//  grant_out    out  2   one-hot current grant {m1,m0}; 2'b00 when idle
//  timeout_out  out  1   one-cycle pulse when the watchdog fires
// BEHAVIOUR
//  Reset (async, active-high): state=IDLE, grant_out=0, watchdog cnt=0, timeout_out=0,
//   s_bus.stb=0, s_bus.we=0, m0/m1 ack=0, err=0; rdata=0 on non-granted master.
//  FSM states: IDLE, BUSY0, BUSY1 (registered grant).
//  IDLE: if m0.stb -> BUSY0; else if m1.stb -> BUSY1; else stay. Decision registered:
//   grant visible the cycle after stb is first seen (1-cycle arbitration latency).
//  BUSYn: s_bus.addr/we/wdata/stb driven combinationally from mN; mN.ack=s_bus.ack,
//   mN.err=s_bus.err, mN.rdata=s_bus.rdata. Other master sees ack=0, err=0, rdata=0.
//  Transfer end: s_bus.ack|s_bus.err sampled high -> IDLE next cycle; one dead IDLE cycle
//   between back-to-back transfers (no re-arbitration inside BUSY).
//  Master abort: mN.stb low while BUSYn -> IDLE next cycle; no ack/err forwarded after.
//  Watchdog: cnt clears on entry to BUSYn, increments each BUSY cycle without ack/err.
//   When cnt==TimeoutCycles-1 and no ack/err: mN.err=1 that cycle (s_bus.stb still high),
//   timeout_out pulses 1 cycle, next state IDLE, cnt saturates/clears. Slave ack in the same
//   cycle wins: ack forwarded, no error, no timeout_out.
//  Simultaneous m0.stb & m1.stb in IDLE: m0 granted (fixed priority), m1 waits in stb.
//  Starvation: fixed priority can starve m1; addressed by the optional feature below.
//  Reset asserted mid-BUSY: immediate return to IDLE, all outputs to reset values.
// CONFIGURATION
//  Macro WB_ARB_ROUND_ROBIN_EN:
//   defined     -> 1-bit last_grant register (reset 1 = m1), on simultaneous requests in IDLE
//                  grant the master NOT granted last; single request granted directly.
//   undefined   -> fixed priority m0 > m1; no last_grant register exists.
// STRUCTURE
//  Package wb_arb_pkg: typedef enum logic [1:0] {ARB_IDLE, ARB_BUSY0, ARB_BUSY1} arb_state_t;
//   localparam logic [1:0] GRANT_NONE=2'b00, GRANT_M0=2'b01, GRANT_M1=2'b10.
//  Sub-module wb_arb_watchdog: clear/enable/expire counter (CntWidth, TimeoutCycles),
//   outputs expire pulse; arbiter owns FSM and muxing.
// TESTING
//  1 m0 read addr 0x10, slave acks 1st BUSY cycle -> grant_out 01 one cycle after stb,
//    m0.ack=1, m0.rdata=slave data, m1 ack/err=0, IDLE next cycle.
//  2 m0&m1 stb same cycle, no macro -> m0 served first, dead cycle, then m1 (grant 01,00,10).
//    With WB_ARB_ROUND_ROBIN_EN after reset -> m0 first; repeat -> m1 first on 2nd conflict.
//  3 m1 write, slave asserts err (we=1) -> m1.err=1 one cycle, m1.ack=0, FSM IDLE.
//  4 slave never acks, TimeoutCycles=16 -> m0.err and timeout_out high exactly in 16th BUSY
//    cycle, IDLE next; ack arriving in that same cycle -> ack only, timeout_out=0.
//  5 m1 drops stb 2 cycles into BUSY1 -> IDLE next cycle, no ack to m1; pending m0 granted.
//  6 reset_in pulsed mid-BUSY0 asynchronously -> grant_out=0, s_bus.stb=0 without clock edge.

Source files
------------

// File: rtl/wb_mem_arbiter_pkg.sv
// Package: wb_arb_pkg
// Shared types and constants for the two-master Wishbone memory arbiter.
//   arb_state_t : arbiter FSM state (IDLE, BUSY0 = m0 owns the bus, BUSY1 = m1 owns it)
//   GRANT_*     : one-hot grant encodings {m1,m0}
//   LAST_*      : encodings of the round-robin last-grant bit
//   grant_of()  : maps a state to its one-hot grant
package wb_arb_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_BUSY0 = 2'd1,
    ARB_BUSY1 = 2'd2
  } arb_state_t;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_M0   = 2'b01;
  localparam logic [1:0] GRANT_M1   = 2'b10;

  localparam logic LAST_M0 = 1'b0;
  localparam logic LAST_M1 = 1'b1;

  function automatic logic [1:0] grant_of(input arb_state_t s);
    case (s)
      ARB_BUSY0: return GRANT_M0;
      ARB_BUSY1: return GRANT_M1;
      default:   return GRANT_NONE;
    endcase
  endfunction

endpackage

// File: rtl/wb_bus.sv
// Interface: wb_bus
// Minimal classic Wishbone point-to-point bundle.
//   stb/we/addr/wdata : request, driven by the master
//   ack/err/rdata     : response, driven by the slave
// Modports: master (drives the request) and slave (drives the response).
interface wb_bus;
  import wb_arb_pkg::*;

  logic              stb;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ack;
  logic              err;

  modport master (output stb, we, addr, wdata, input rdata, ack, err);
  modport slave  (input stb, we, addr, wdata, output rdata, ack, err);

endinterface

// File: rtl/wb_mem_arbiter_watchdog.sv
// Module: wb_arb_watchdog
// Bus watchdog counter. Counts enabled cycles since the last clear and flags
// expiry in the cycle where the count reaches TimeoutCycles-1 while enabled.
// Ports:
//   clk_i     : clock
//   rst_i     : asynchronous active-high reset
//   clear_i   : force the count back to zero (held while the bus is idle)
//   enable_i  : count this cycle (busy cycle with no slave response)
//   expire_o  : combinational expiry flag, high for one cycle at most
module wb_arb_watchdog #(
  parameter int TimeoutCycles = 16,
  parameter int CntWidth      = 5
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_o
);

  localparam logic [CntWidth-1:0] CNT_LAST = CntWidth'(TimeoutCycles - 1);

  logic [CntWidth-1:0] cnt_q, cnt_d;

  assign expire_o = enable_i && (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d = cnt_q;
    // Expiry ends the transfer, so the count restarts rather than wrapping.
    if (clear_i || expire_o) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = cnt_q + CntWidth'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/wb_mem_arbiter.sv
// Module: wb_mem_arbiter
// Two-master Wishbone arbiter in front of the single-port program memory.
// m0 is instruction fetch, m1 is load/store data. One master owns the slave
// at a time; the grant is registered, so a request is granted the cycle after
// its stb is first seen, and every transfer is followed by one idle cycle.
// A watchdog errors a transfer the slave leaves unanswered for TimeoutCycles.
//
// Handshake: a transfer is live while the owning master holds stb high. It
// completes in the cycle the slave raises ack or err (forwarded to the owner
// in that same cycle). Dropping stb before that aborts it; nothing is
// forwarded after the abort.
//
// Ports:
//   clk_in      : clock, all state on posedge
//   reset_in    : asynchronous active-high reset
//   m0_bus      : instruction-fetch master (wins ties in the default build)
//   m1_bus      : data master
//   s_bus       : program memory slave
//   grant_out   : one-hot current owner {m1,m0}, 2'b00 when idle
//   timeout_out : one-cycle pulse when the watchdog errors a transfer
//   state_out   : FSM state, for debug observation
//
// Build option WB_ARB_ROUND_ROBIN_EN: when defined, a simultaneous request in
// IDLE goes to the master that was not granted last (last-grant bit resets to
// m1, so the first conflict goes to m0). Undefined: fixed priority m0 > m1.
module wb_mem_arbiter
  import wb_arb_pkg::*;
#(
  parameter int TimeoutCycles = 16,
  parameter int CntWidth      = 5
) (
  input  logic        clk_in,
  input  logic        reset_in,
  wb_bus.slave        m0_bus,
  wb_bus.slave        m1_bus,
  wb_bus.master       s_bus,
  output logic [1:0]  grant_out,
  output logic        timeout_out,
  output arb_state_t  state_out
);

  arb_state_t state_q, state_d;

`ifdef WB_ARB_ROUND_ROBIN_EN
  logic last_q, last_d;
`endif

  logic              busy;
  logic              xfer_end;
  logic              wd_clear;
  logic              wd_enable;
  logic              wd_expire;
  logic              sel_stb;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // Request of whichever master currently owns the bus.
  always_comb begin
    if (state_q == ARB_BUSY1) begin
      sel_stb   = m1_bus.stb;
      sel_we    = m1_bus.we;
      sel_addr  = m1_bus.addr;
      sel_wdata = m1_bus.wdata;
    end else begin
      sel_stb   = m0_bus.stb;
      sel_we    = m0_bus.we;
      sel_addr  = m0_bus.addr;
      sel_wdata = m0_bus.wdata;
    end
  end

  assign busy      = (state_q != ARB_IDLE);
  assign xfer_end  = s_bus.ack | s_bus.err;
  // Counter holds at zero in IDLE, so each BUSY period starts from zero.
  // A slave response in the last cycle keeps enable low: ack beats timeout.
  assign wd_clear  = !busy;
  assign wd_enable = busy && sel_stb && !xfer_end;

  wb_arb_watchdog #(
    .TimeoutCycles (TimeoutCycles),
    .CntWidth      (CntWidth)
  ) u_watchdog (
    .clk_i    (clk_in),
    .rst_i    (reset_in),
    .clear_i  (wd_clear),
    .enable_i (wd_enable),
    .expire_o (wd_expire)
  );

  always_comb begin
    state_d       = state_q;
    s_bus.stb     = 1'b0;
    s_bus.we      = 1'b0;
    s_bus.addr    = '0;
    s_bus.wdata   = '0;
    m0_bus.ack    = 1'b0;
    m0_bus.err    = 1'b0;
    m0_bus.rdata  = '0;
    m1_bus.ack    = 1'b0;
    m1_bus.err    = 1'b0;
    m1_bus.rdata  = '0;
    timeout_out   = 1'b0;
`ifdef WB_ARB_ROUND_ROBIN_EN
    last_d        = last_q;
`endif

    case (state_q)
      ARB_IDLE: begin
`ifdef WB_ARB_ROUND_ROBIN_EN
        if (m0_bus.stb && m1_bus.stb) begin
          if (last_q == LAST_M1) begin
            state_d = ARB_BUSY0;
            last_d  = LAST_M0;
          end else begin
            state_d = ARB_BUSY1;
            last_d  = LAST_M1;
          end
        end else if (m0_bus.stb) begin
          state_d = ARB_BUSY0;
          last_d  = LAST_M0;
        end else if (m1_bus.stb) begin
          state_d = ARB_BUSY1;
          last_d  = LAST_M1;
        end
`else
        if (m0_bus.stb) begin
          state_d = ARB_BUSY0;
        end else if (m1_bus.stb) begin
          state_d = ARB_BUSY1;
        end
`endif
      end

      ARB_BUSY0, ARB_BUSY1: begin
        s_bus.stb   = sel_stb;
        s_bus.we    = sel_we;
        s_bus.addr  = sel_addr;
        s_bus.wdata = sel_wdata;
        // Responses are gated by stb so an aborting master sees nothing.
        if (state_q == ARB_BUSY0) begin
          m0_bus.ack   = sel_stb & s_bus.ack;
          m0_bus.err   = sel_stb & (s_bus.err | wd_expire);
          m0_bus.rdata = s_bus.rdata;
        end else begin
          m1_bus.ack   = sel_stb & s_bus.ack;
          m1_bus.err   = sel_stb & (s_bus.err | wd_expire);
          m1_bus.rdata = s_bus.rdata;
        end
        timeout_out = wd_expire;
        if (!sel_stb || xfer_end || wd_expire) begin
          state_d = ARB_IDLE;
        end
      end

      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state_q <= ARB_IDLE;
`ifdef WB_ARB_ROUND_ROBIN_EN
      last_q  <= LAST_M1;
`endif
    end else begin
      state_q <= state_d;
`ifdef WB_ARB_ROUND_ROBIN_EN
      last_q  <= last_d;
`endif
    end
  end

  assign grant_out = grant_of(state_q);
  assign state_out = state_q;

endmodule
